cache_refill_ctrl: RTL and testbench

Sequencing controller for the 16-set, 4-word-line direct-mapped data cache. It checks CPU accesses against the tag/data arrays and stalls the CPU on a read miss. On a miss it fetches the whole 4-word line from main memory one word per handshake, then writes the line into the cache in a single cycle. Stores are written through to memory, and the cached word is updated or invalidated. It sits between the CPU load/store port, the cache arrays, and the word-wide RAM port.

---
 rtl/cache_refill_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_cache_refill_ctrl.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cache_refill_ctrl
// Purpose  : Lookup/refill/write-through sequencer for a 16-set, 4-word-line
//            direct-mapped data cache sitting between CPU, arrays and RAM.
// Revision : 1.0
// ============================================================================
module cache_refill_ctrl #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32,
    parameter int TAG_WIDTH     = 8,
    parameter int INDEX_WIDTH   = 4,
    parameter int LINE_WIDTH    = 137,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0]    cpu_wdata,
    input  logic [1:0]               cpu_dtype,
    output logic [DATA_WIDTH-1:0]    cpu_rdata,
    output logic                     cpu_ready,
    output logic [INDEX_WIDTH-1:0]   cache_index,
    input  logic [LINE_WIDTH-1:0]    cache_rline,
    output logic                     cache_we,
    output logic [LINE_WIDTH-1:0]    cache_wline,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    output logic [1:0]               mem_dtype,
    input  logic                     mem_ack,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    output logic [COUNT_WIDTH-1:0]   hit_count,
    output logic [COUNT_WIDTH-1:0]   miss_count
);

    localparam int       c_VALID_BIT = LINE_WIDTH - 1;
    localparam int       c_TAG_LSB   = 4 * DATA_WIDTH;
    localparam int       c_IDX_LSB   = 4;
    localparam logic [1:0] c_DT_WORD = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FILL    = 3'd1,
        ST_LINE_WR = 3'd2,
        ST_WRITE   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t                          state_q;
    logic [1:0]                      beat_q;
    logic [3:0][DATA_WIDTH-1:0]      buf_q;
    logic [ADDRESS_WIDTH-1:0]        addr_q;
    logic [DATA_WIDTH-1:0]           wdata_q;
    logic [1:0]                      dtype_q;
    logic                            we_q;
    logic                            hit_q;
    logic [COUNT_WIDTH-1:0]          hit_cnt_q;
    logic [COUNT_WIDTH-1:0]          miss_cnt_q;

    logic [3:0][DATA_WIDTH-1:0]      w_rwords;
    logic [3:0][DATA_WIDTH-1:0]      w_mod_words;
    logic [TAG_WIDTH-1:0]            w_rd_tag;
    logic [TAG_WIDTH-1:0]            w_cpu_tag;
    logic                            w_hit;
    logic                            w_load_hit;
    logic                            w_unused;

    assign w_rwords   = cache_rline[4*DATA_WIDTH-1:0];
    assign w_rd_tag   = cache_rline[c_TAG_LSB +: TAG_WIDTH];
    assign w_cpu_tag  = cpu_addr[ADDRESS_WIDTH-1 -: TAG_WIDTH];
    assign w_hit      = cache_rline[c_VALID_BIT] && (w_rd_tag == w_cpu_tag);
    assign w_load_hit = (state_q == ST_IDLE) && cpu_req && !cpu_we && w_hit;
    assign w_unused   = &{1'b0, addr_q[1:0]};

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

    always_comb begin
        w_mod_words              = w_rwords;
        w_mod_words[addr_q[3:2]] = wdata_q;
    end

    // Outputs are forced quiet while reset is held so an in-flight
    // operation can neither write the arrays nor complete.
    always_comb begin
        cpu_ready   = 1'b0;
        cpu_rdata   = '0;
        cache_index = addr_q[c_IDX_LSB +: INDEX_WIDTH];
        cache_we    = 1'b0;
        cache_wline = '0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_dtype   = 2'b00;
        if (state_q == ST_IDLE) begin
            cache_index = cpu_addr[c_IDX_LSB +: INDEX_WIDTH];
        end
        if (!rst) begin
            case (state_q)
                ST_IDLE: begin
                    if (w_load_hit) begin
                        cpu_ready = 1'b1;
                        cpu_rdata = w_rwords[cpu_addr[3:2]];
                    end
                end
                ST_FILL: begin
                    mem_req  = 1'b1;
                    mem_addr = {addr_q[ADDRESS_WIDTH-1:4], beat_q, 2'b00};
                end
                ST_LINE_WR: begin
                    cache_we    = 1'b1;
                    cache_wline = {1'b1, addr_q[ADDRESS_WIDTH-1 -: TAG_WIDTH], buf_q};
                end
                ST_WRITE: begin
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = {addr_q[ADDRESS_WIDTH-1:2], 2'b00};
                    mem_wdata = wdata_q;
                    mem_dtype = dtype_q;
                    if (mem_ack && hit_q) begin
                        cache_we = 1'b1;
                        if (dtype_q == c_DT_WORD) begin
                            cache_wline = {cache_rline[LINE_WIDTH-1:c_TAG_LSB], w_mod_words};
                        end else begin
                            // Partial stores drop the line rather than merge lanes.
                            cache_wline              = cache_rline;
                            cache_wline[c_VALID_BIT] = 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    cpu_ready = 1'b1;
                    if (!we_q) begin
                        cpu_rdata = buf_q[addr_q[3:2]];
                    end
                end
                default: begin
                    cpu_ready = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            beat_q     <= 2'd0;
            buf_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            dtype_q    <= 2'b00;
            we_q       <= 1'b0;
            hit_q      <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cpu_req) begin
                        if (cpu_we) begin
                            addr_q  <= cpu_addr;
                            wdata_q <= cpu_wdata;
                            dtype_q <= cpu_dtype;
                            we_q    <= 1'b1;
                            hit_q   <= w_hit;
                            state_q <= ST_WRITE;
                        end else if (w_hit) begin
                            if (hit_cnt_q != '1) begin
                                hit_cnt_q <= hit_cnt_q + COUNT_WIDTH'(1);
                            end
                        end else begin
                            addr_q  <= cpu_addr;
                            we_q    <= 1'b0;
                            beat_q  <= 2'd0;
                            state_q <= ST_FILL;
                            if (miss_cnt_q != '1) begin
                                miss_cnt_q <= miss_cnt_q + COUNT_WIDTH'(1);
                            end
                        end
                    end
                end
                ST_FILL: begin
                    if (mem_ack) begin
                        buf_q[beat_q] <= mem_rdata;
                        if (beat_q == 2'd3) begin
                            state_q <= ST_LINE_WR;
                        end else begin
                            beat_q <= beat_q + 2'd1;
                        end
                    end
                end
                ST_LINE_WR: begin
                    state_q <= ST_DONE;
                end
                ST_WRITE: begin
                    if (mem_ack) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_refill_ctrl
// Purpose  : Directed bench with transaction-level cache/memory model.
// Revision : 1.0
// ============================================================================
module tb_cache_refill_ctrl;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [31:0] wd;
        logic [1:0]  dt;
    } mop_t;

    typedef struct {
        logic [3:0]   idx;
        logic [136:0] line;
    } cw_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_req, cpu_we;
    logic [15:0]  cpu_addr;
    logic [31:0]  cpu_wdata;
    logic [1:0]   cpu_dtype;
    logic [31:0]  cpu_rdata;
    logic         cpu_ready;
    logic [3:0]   cache_index;
    logic [136:0] cache_rline;
    logic         cache_we;
    logic [136:0] cache_wline;
    logic         mem_req, mem_we;
    logic [15:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic [1:0]   mem_dtype;
    logic         mem_ack;
    logic [31:0]  mem_rdata;
    logic [15:0]  hit_count, miss_count;

    always #5 clk = ~clk;

    cache_refill_ctrl dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_dtype(cpu_dtype),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .cache_index(cache_index), .cache_rline(cache_rline),
        .cache_we(cache_we), .cache_wline(cache_wline),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_dtype(mem_dtype),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    // Environment: cache arrays and word-wide RAM
    logic [136:0] arr [16] = '{default: '0};
    logic [31:0]  emem [16384];
    int           wait_n = 0;
    int           cyc = 0;

    assign cache_rline = arr[cache_index];
    always @(posedge clk) if (cache_we) arr[cache_index] <= cache_wline;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] pat(input int w);
        return {16'hC0DE, w[13:0], 2'b00};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [1:0] dt);
        if (dt == 2'b01) return {old[31:8], wd[7:0]};
        if (dt == 2'b10) return {old[31:16], wd[15:0]};
        return wd;
    endfunction

    initial begin
        int wc;
        wc = 0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        for (int i = 0; i < 16384; i++) emem[i] = pat(i);
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (mem_req) begin
                if (wc >= wait_n) begin
                    mem_ack   = 1'b1;
                    mem_rdata = emem[mem_addr[15:2]];
                    if (mem_we) emem[mem_addr[15:2]] = merge(emem[mem_addr[15:2]], mem_wdata, mem_dtype);
                    wc = 0;
                end else begin
                    wc++;
                end
            end else begin
                wc = 0;
            end
        end
    end

    // Reference model
    logic [31:0]      rmem [16384];
    logic             mv [16];
    logic [7:0]       mt [16];
    logic [3:0][31:0] md [16];
    logic [15:0]      m_hits, m_misses;
    mop_t             mq [$];
    cw_t              cq [$];
    logic [15:0]      mlog [$];

    int           n_cmp = 0;
    int           n_bad = 0;
    logic         pend = 1'b0;
    int           start, exp_lat, last_lat, cw_count;
    logic         exp_we;
    logic [31:0]  exp_rd, last_rdata;
    logic [136:0] last_cline;
    logic [3:0]   last_cidx;

    task automatic chk(input string nm, input logic [136:0] act, input logic [136:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic d);
        if (!d || v == 16'hFFFF) return v;
        return v + 16'd1;
    endfunction

    task automatic predict(input logic we, input logic [15:0] a, input logic [31:0] wd,
                           input logic [1:0] dt, input logic abort, output int lat,
                           output logic [31:0] rd, output logic dh, output logic dm);
        logic [3:0] idx;
        logic [7:0] tag;
        logic [1:0] off;
        logic       hit;
        mop_t       m;
        cw_t        c;
        idx = a[7:4];
        tag = a[15:8];
        off = a[3:2];
        hit = mv[idx] && (mt[idx] == tag);
        dh = 1'b0;
        dm = 1'b0;
        rd = '0;
        if (!we) begin
            if (hit) begin
                dh  = 1'b1;
                lat = 0;
                rd  = md[idx][off];
            end else begin
                dm  = 1'b1;
                lat = 4 * (wait_n + 1) + 2;
                rd  = rmem[a[15:2]];
                for (int b = 0; b < 4; b++) begin
                    m.addr = {a[15:4], 2'(b), 2'b00};
                    m.we = 1'b0; m.wd = '0; m.dt = 2'b00;
                    mq.push_back(m);
                end
                if (!abort) begin
                    for (int b = 0; b < 4; b++) md[idx][b] = rmem[{a[15:4], 2'(b)}];
                    mv[idx] = 1'b1;
                    mt[idx] = tag;
                    c.idx  = idx;
                    c.line = {1'b1, tag, md[idx]};
                    cq.push_back(c);
                end
            end
        end else begin
            lat = wait_n + 2;
            m.addr = {a[15:2], 2'b00}; m.we = 1'b1; m.wd = wd; m.dt = dt;
            mq.push_back(m);
            rmem[a[15:2]] = merge(rmem[a[15:2]], wd, dt);
            if (hit) begin
                if (dt == 2'b00) md[idx][off] = wd;
                else mv[idx] = 1'b0;
                c.idx  = idx;
                c.line = {mv[idx], tag, md[idx]};
                cq.push_back(c);
            end
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("quiet_in_reset", 137'({cache_we, cpu_ready, mem_req}), 137'(0));
            end else begin
                chk("hit_count", 137'(hit_count), 137'(m_hits));
                chk("miss_count", 137'(miss_count), 137'(m_misses));
                if (mem_req) begin
                    if (mq.size() == 0) begin
                        chk("unexpected_mem_req", 137'(mem_req), 137'(0));
                    end else begin
                        chk("mem_addr", 137'(mem_addr), 137'(mq[0].addr));
                        chk("mem_we", 137'(mem_we), 137'(mq[0].we));
                        chk("mem_dtype", 137'(mem_dtype), 137'(mq[0].dt));
                        if (mq[0].we) chk("mem_wdata", 137'(mem_wdata), 137'(mq[0].wd));
                        if (mem_ack) begin
                            mlog.push_back(mem_addr);
                            mq.delete(0);
                        end
                    end
                end
                if (cache_we) begin
                    cw_count++;
                    if (cq.size() == 0) begin
                        chk("unexpected_cache_we", 137'(cache_we), 137'(0));
                    end else begin
                        chk("cache_index", 137'(cache_index), 137'(cq[0].idx));
                        chk("cache_wline", cache_wline, cq[0].line);
                        last_cline = cache_wline;
                        last_cidx  = cache_index;
                        cq.delete(0);
                    end
                end
                if (cpu_ready) begin
                    if (!pend) begin
                        chk("unexpected_cpu_ready", 137'(cpu_ready), 137'(0));
                    end else begin
                        last_lat = cyc - start;
                        chk("latency", 137'(last_lat), 137'(exp_lat));
                        if (!exp_we) chk("cpu_rdata", 137'(cpu_rdata), 137'(exp_rd));
                        last_rdata = cpu_rdata;
                        pend = 1'b0;
                    end
                end
            end
        end
    endtask

    // Called aligned to 1 time unit after a rising edge; returns likewise.
    task automatic access(input logic we, input logic [15:0] a, input logic [31:0] wd,
                          input logic [1:0] dt);
        int          lat, n;
        logic [31:0] rd;
        logic        dh, dm;
        predict(we, a, wd, dt, 1'b0, lat, rd, dh, dm);
        exp_lat = lat; exp_rd = rd; exp_we = we;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_dtype = dt;
        start = cyc;
        pend = 1'b1;
        @(posedge clk);
        #1;
        m_hits   = sat_inc(m_hits, dh);
        m_misses = sat_inc(m_misses, dm);
        n = 0;
        while (pend && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (pend) begin
            chk("ready_timeout", 137'(pend), 137'(0));
            pend = 1'b0;
        end
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
    endtask

    logic [15:0] tbl [4] = '{16'hA100, 16'hB214, 16'hC328, 16'hD43C};

    initial begin
        int          lat, n, cw0;
        logic [31:0] rd;
        logic        dh, dm;
        rst = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_dtype = 2'b00;
        m_hits = '0; m_misses = '0; cw_count = 0;
        last_lat = -1; last_rdata = '0; last_cline = '0; last_cidx = '0;
        for (int i = 0; i < 16384; i++) rmem[i] = pat(i);
        for (int i = 0; i < 16; i++) begin mv[i] = 1'b0; mt[i] = '0; md[i] = '0; end
        fork
            compare_loop();
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outs", 137'({cpu_ready, mem_req, mem_we, cache_we}), 137'(0));
        chk("rst_rdata", 137'(cpu_rdata), 137'(0));
        chk("rst_mem_addr", 137'(mem_addr), 137'(0));
        chk("rst_mem_wdata", 137'(mem_wdata), 137'(0));
        chk("rst_counts", 137'({hit_count, miss_count}), 137'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Cold miss
        mlog.delete();
        access(1'b0, 16'h1234, '0, 2'b00);
        chk("miss1_rdata", 137'(last_rdata), 137'(32'hC0DE1234));
        chk("miss1_latency", 137'(last_lat), 137'(6));
        chk("miss1_beats", 137'({mlog[0], mlog[1], mlog[2], mlog[3]}), 137'(64'h1230_1234_1238_123C));
        chk("miss1_line_idx_tag", 137'({last_cidx, last_cline[136:128]}), 137'({4'd3, 1'b1, 8'h12}));
        chk("miss1_count", 137'(miss_count), 137'(1));

        mlog.delete();
        access(1'b0, 16'h1238, '0, 2'b00);
        chk("hit1_rdata", 137'(last_rdata), 137'(32'hC0DE1238));
        chk("hit1_latency", 137'(last_lat), 137'(0));
        chk("hit1_count", 137'(hit_count), 137'(1));
        chk("hit1_no_mem", 137'(mlog.size()), 137'(0));

        // Conflict eviction and re-miss
        access(1'b0, 16'h2234, '0, 2'b00);
        chk("conflict_rdata", 137'(last_rdata), 137'(32'hC0DE2234));
        access(1'b0, 16'h1234, '0, 2'b00);
        chk("remiss_latency", 137'(last_lat), 137'(6));
        chk("remiss_count", 137'(miss_count), 137'(3));

        // Word store hit updates the line in place
        access(1'b1, 16'h1234, 32'hDEADBEEF, 2'b00);
        chk("wstore_latency", 137'(last_lat), 137'(2));
        chk("wstore_word1", 137'({last_cline[136:128], last_cline[63:32]}), 137'({1'b1, 8'h12, 32'hDEADBEEF}));
        access(1'b0, 16'h1234, '0, 2'b00);
        chk("wstore_readback", 137'({last_lat[7:0], last_rdata}), 137'({8'd0, 32'hDEADBEEF}));

        // Byte store invalidates
        access(1'b1, 16'h1238, 32'h000000AB, 2'b01);
        chk("bstore_invalid", 137'(last_cline[136]), 137'(0));
        access(1'b0, 16'h123C, '0, 2'b00);
        chk("bstore_remiss", 137'(last_lat), 137'(6));
        access(1'b0, 16'h1238, '0, 2'b00);
        chk("bstore_merged", 137'(last_rdata), 137'(32'hC0DE12AB));
        access(1'b0, 16'h1234, '0, 2'b00);
        chk("wt_survives", 137'(last_rdata), 137'(32'hDEADBEEF));

        // Store miss: no allocate
        cw0 = cw_count;
        access(1'b1, 16'h5670, 32'h13572468, 2'b00);
        chk("smiss_no_cache_we", 137'(cw_count), 137'(cw0));
        access(1'b0, 16'h5670, '0, 2'b00);
        chk("smiss_readback", 137'(last_rdata), 137'(32'h13572468));

        // Halfword store invalidates
        access(1'b1, 16'h1230, 32'hFFFF9999, 2'b10);
        access(1'b0, 16'h1230, '0, 2'b00);
        chk("hstore_remiss", 137'({last_lat[7:0], last_rdata}), 137'({8'd6, 32'hC0DE9999}));

        // Table: fill four sets, then all must hit
        for (int i = 0; i < 4; i++) access(1'b0, tbl[i], '0, 2'b00);
        for (int i = 0; i < 4; i++) begin
            access(1'b0, tbl[i], '0, 2'b00);
            chk("table_hit_latency", 137'(last_lat), 137'(0));
        end

        // Slow memory
        wait_n = 3;
        access(1'b0, 16'h4440, '0, 2'b00);
        chk("slow_miss_latency", 137'(last_lat), 137'(18));
        chk("slow_miss_rdata", 137'(last_rdata), 137'(32'hC0DE4440));
        access(1'b1, 16'h4444, 32'h0BADF00D, 2'b00);
        chk("slow_store_latency", 137'(last_lat), 137'(5));
        access(1'b0, 16'h4444, '0, 2'b00);
        chk("slow_store_readback", 137'(last_rdata), 137'(32'h0BADF00D));

        // Reset during beat 2 of a slow fill
        predict(1'b0, 16'h7770, '0, 2'b00, 1'b1, lat, rd, dh, dm);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h7770;
        @(posedge clk);
        #1;
        m_misses = sat_inc(m_misses, dm);
        n = 0;
        while (!(mem_req && mem_addr == 16'h7778) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("abort_reach_beat2", 137'({mem_req, mem_addr}), 137'({1'b1, 16'h7778}));
        rst = 1'b1;
        cpu_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_hits = '0;
        m_misses = '0;
        mq.delete();
        cw0 = cw_count;
        chk("abort_idle", 137'({mem_req, cpu_ready, cache_we}), 137'(0));
        repeat (25) @(posedge clk);
        #1;
        chk("abort_no_cache_we", 137'(cw_count), 137'(cw0));

        wait_n = 0;
        access(1'b0, 16'h7770, '0, 2'b00);
        chk("post_abort_miss", 137'({last_lat[7:0], miss_count}), 137'({8'd6, 16'd1}));

        repeat (3) @(posedge clk);
        chk("mq_drained", 137'(mq.size()), 137'(0));
        chk("cq_drained", 137'(cq.size()), 137'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
